// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU: datapath width and opcode encodings.
package alu_pkg;

    localparam int W = 4;

    // Shift amounts at or above this value clear the result.
    localparam logic [W-1:0] SHAMT_LIMIT = W[W-1:0];

    localparam logic [3:0] OP_RED_OR  = 4'b0000;
    localparam logic [3:0] OP_RED_AND = 4'b0001;
    localparam logic [3:0] OP_RED_XOR = 4'b0010;
    localparam logic [3:0] OP_AND     = 4'b0011;
    localparam logic [3:0] OP_OR      = 4'b0100;
    localparam logic [3:0] OP_XOR     = 4'b0101;
    localparam logic [3:0] OP_GT      = 4'b0110;
    localparam logic [3:0] OP_LT      = 4'b0111;
    localparam logic [3:0] OP_NOT     = 4'b1000;
    localparam logic [3:0] OP_EQ      = 4'b1001;
    localparam logic [3:0] OP_ADD     = 4'b1010;
    localparam logic [3:0] OP_SUB     = 4'b1011;
    localparam logic [3:0] OP_MUL     = 4'b1100;
    localparam logic [3:0] OP_SHR     = 4'b1101;
    localparam logic [3:0] OP_SHL     = 4'b1110;
    localparam logic [3:0] OP_NOT2    = 4'b1111;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and datapath for the ALU; produces next x/y.
module alu_comb
    import alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   opcode,
    output logic [W-1:0] next_x,
    output logic [W-1:0] next_y
);

    localparam logic [W-2:0] ZPAD = '0;

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] prod;

    // Decode the opcode; unary branches never touch b so an unknown b cannot leak in.
    always_comb begin
        next_x = '0;
        next_y = '0;
        sum    = '0;
        diff   = '0;
        prod   = '0;
        case (opcode)
            OP_RED_OR:  next_x = {ZPAD, |a};
            OP_RED_AND: next_x = {ZPAD, &a};
            OP_RED_XOR: next_x = {ZPAD, ^a};
            OP_AND:     next_x = a & b;
            OP_OR:      next_x = a | b;
            OP_XOR:     next_x = a ^ b;
            OP_GT:      next_x = {ZPAD, (a > b)};
            OP_LT:      next_x = {ZPAD, (a < b)};
            OP_NOT:     next_x = ~a;
            OP_EQ:      next_x = {ZPAD, (a == b)};
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                next_x = sum[W-1:0];
                next_y = {ZPAD, sum[W]};
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow (a < b).
                diff   = {1'b0, a} - {1'b0, b};
                next_x = diff[W-1:0];
                next_y = {ZPAD, diff[W]};
            end
            OP_MUL: begin
                prod   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                next_x = prod[W-1:0];
                next_y = prod[2*W-1:W];
            end
            OP_SHR: begin
                if (b >= SHAMT_LIMIT) next_x = '0;
                else                  next_x = a >> b;
            end
            OP_SHL: begin
                if (b >= SHAMT_LIMIT) next_x = '0;
                else                  next_x = a << b;
            end
            OP_NOT2:    next_x = ~a;
            // Unknown opcode drives zeros rather than letting outputs hold stale data.
            default: begin
                next_x = '0;
                next_y = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 4-bit, 16-operation ALU top: one-cycle registered x/y around alu_comb.
module alu
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   opcode,
    output logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] x_d;
    logic [W-1:0] y_d;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;

    alu_comb u_comb (
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .next_x (x_d),
        .next_y (y_d)
    );

    // Output registers; synchronous active-low reset takes priority over any op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu with hand-computed expected values.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] opcode;
    logic [3:0] x;
    logic [3:0] y;

    int n_checks;
    int n_pass;
    int n_fail;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .x      (x),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] ex, input logic [3:0] ey);
        n_checks++;
        assert (x === ex) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s x: got %b expected %b", tag, x, ex);
        end
        n_checks++;
        assert (y === ey) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s y: got %b expected %b", tag, y, ey);
        end
    endtask

    // Apply one op, clock one edge, sample 1 time unit later and check.
    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] va,
                        input logic [3:0] vb, input logic [3:0] ex, input logic [3:0] ey);
        opcode = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        check(tag, ex, ey);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;

        // Reset held for two edges with a live multiply on the inputs
        rst_n  = 1'b0;
        opcode = 4'b1100;
        a      = 4'b1111;
        b      = 4'b1111;
        @(posedge clk);
        #1;
        check("reset_edge1", 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_edge2", 4'b0000, 4'b0000);

        // First op after release appears after one edge
        rst_n = 1'b1;
        step("first_op_add", 4'b1010, 4'b0011, 4'b0101, 4'b1000, 4'b0000);

        // Reductions / unary with unknown b
        step("red_or",   4'b0000, 4'b1101, 4'bxxxx, 4'b0001, 4'b0000);
        step("red_and",  4'b0001, 4'b1010, 4'bxxxx, 4'b0000, 4'b0000);
        step("red_and1", 4'b0001, 4'b1111, 4'bxxxx, 4'b0001, 4'b0000);
        step("red_xor",  4'b0010, 4'b1111, 4'bxxxx, 4'b0000, 4'b0000);
        step("red_xor1", 4'b0010, 4'b0111, 4'bxxxx, 4'b0001, 4'b0000);
        step("not",      4'b1000, 4'b1100, 4'bxxxx, 4'b0011, 4'b0000);
        step("not2",     4'b1111, 4'b1100, 4'bxxxx, 4'b0011, 4'b0000);
        step("red_or0",  4'b0000, 4'b0000, 4'bxxxx, 4'b0000, 4'b0000);

        // Bitwise / compare
        step("and",      4'b0011, 4'b1100, 4'b1010, 4'b1000, 4'b0000);
        step("or",       4'b0100, 4'b1100, 4'b1010, 4'b1110, 4'b0000);
        step("xor",      4'b0101, 4'b1100, 4'b1010, 4'b0110, 4'b0000);
        step("gt_true",  4'b0110, 4'b1101, 4'b1010, 4'b0001, 4'b0000);
        step("gt_false", 4'b0110, 4'b0101, 4'b1010, 4'b0000, 4'b0000);
        step("lt_true",  4'b0111, 4'b0101, 4'b1010, 4'b0001, 4'b0000);
        step("lt_eq",    4'b0111, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
        step("eq_true",  4'b1001, 4'b1010, 4'b1010, 4'b0001, 4'b0000);
        step("eq_false", 4'b1001, 4'b1010, 4'b1011, 4'b0000, 4'b0000);

        // Arithmetic
        step("add",       4'b1010, 4'b0011, 4'b0101, 4'b1000, 4'b0000);
        step("add_carry", 4'b1010, 4'b1111, 4'b0001, 4'b0000, 4'b0001);
        step("sub",       4'b1011, 4'b1011, 4'b0110, 4'b0101, 4'b0000);
        step("sub_borrow",4'b1011, 4'b0001, 4'b0010, 4'b1111, 4'b0001);

        // Multiply
        step("mul_small", 4'b1100, 4'b0011, 4'b0010, 4'b0110, 4'b0000);
        step("mul_max",   4'b1100, 4'b1111, 4'b1111, 4'b0001, 4'b1110);
        step("mul_mid",   4'b1100, 4'b0101, 4'b0110, 4'b1110, 4'b0001);

        // Shifts, including out-of-range amounts
        step("shr1",     4'b1101, 4'b1100, 4'b0001, 4'b0110, 4'b0000);
        step("shl1",     4'b1110, 4'b1100, 4'b0001, 4'b1000, 4'b0000);
        step("shr3",     4'b1101, 4'b1100, 4'b0011, 4'b0001, 4'b0000);
        step("shl3",     4'b1110, 4'b0011, 4'b0011, 4'b1000, 4'b0000);
        step("shr_b4",   4'b1101, 4'b1111, 4'b0100, 4'b0000, 4'b0000);
        step("shl_b4",   4'b1110, 4'b1111, 4'b0100, 4'b0000, 4'b0000);
        step("shr_b15",  4'b1101, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        step("shl_b15",  4'b1110, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

        // Unknown opcode with zero operands gives zeros
        step("op_x",     4'bxxxx, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset mid-run wins over an op that would set the carry
        rst_n = 1'b0;
        step("reset_wins", 4'b1010, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        step("after_reset", 4'b1100, 4'b1111, 4'b1111, 4'b0001, 4'b1110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
